// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents:
//   hz_state_e    FSM encoding (RUN, PEND, FROZEN)
//   STG_*         stage index constants, IF = 0 ... WB = 4
//   highest_idx   index of the highest set bit of a vector
//   thermo_mask   mask with bits 0..idx set
// The helpers work on MAX_W-bit vectors; callers size-cast the results.
// This limits STAGES to at most MAX_W.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PEND   = 2'd1,
      ST_FROZEN = 2'd2
   } hz_state_e;

   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;
   localparam int STG_WB  = 4;

   localparam int MAX_W     = 32;
   localparam int MAX_IDX_W = 5;

   function automatic logic [MAX_IDX_W-1:0] highest_idx(input logic [MAX_W-1:0] vec);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (vec[i]) idx = MAX_IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [MAX_W-1:0] thermo_mask(input logic [MAX_IDX_W-1:0] idx);
      logic [MAX_W-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_W; i++) begin
         m[i] = (i <= int'(idx));
      end
      return m;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_prio.sv
// prio_thermo: priority encoder for the highest set bit, plus a thermometer mask.
// Ports:
//   i_vec    request vector, W bits
//   o_idx    index of the highest set bit; 0 when no bit is set
//   o_valid  at least one bit is set
//   o_mask   bits 0..o_idx set; all zeros when o_valid is low
module prio_thermo
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int W  = 5,
   parameter int IW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [W-1:0]  i_vec,
   output logic [IW-1:0] o_idx,
   output logic          o_valid,
   output logic [W-1:0]  o_mask
);

   logic [MAX_IDX_W-1:0] w_idx_full;

   assign w_idx_full = highest_idx(MAX_W'(i_vec));
   assign o_idx      = IW'(w_idx_full);
   assign o_valid    = |i_vec;
   assign o_mask     = o_valid ? W'(thermo_mask(w_idx_full)) : '0;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: merges per-stage stall and flush requests into per-stage
// hold (stall) and bubble (flush) commands. It keeps a flush that is blocked
// by an older stall, or by a frozen pipe, until that flush can be applied.
// It also contains a stall watchdog and the stall/flush performance counters.
// Stage 0 is IF; stage STAGES-1 is the oldest stage (WB).
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_rdy               chip ready; low freezes the pipe
//   i_stall_req         per-stage stall requests
//   i_flush_req         per-stage flush requests
//   i_flush_pc          redirect target of stage k in [k*PC_W +: PC_W]
//   o_stall_cmd         per-stage hold
//   o_flush_cmd         per-stage bubble load
//   o_redirect_valid/pc fetch redirect
//   o_wd_timeout        sticky flag for a runaway stall
//   o_stall_cnt         count of stalled ready cycles
//   o_flush_cnt         count of applied flushes
//
// state  | meaning
// RUN    | no pending flush
// PEND   | blocked flush held in the pending register
// FROZEN | rdy low; r_frz_pend records whether a flush is pending
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int STAGES   = 5,
   parameter int PC_W     = 32,
   parameter int WD_W     = 8,
   parameter int WD_LIMIT = 200,
   parameter int CNT_W    = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_rdy,
   input  logic [STAGES-1:0]      i_stall_req,
   input  logic [STAGES-1:0]      i_flush_req,
   input  logic [STAGES*PC_W-1:0] i_flush_pc,
   output logic [STAGES-1:0]      o_stall_cmd,
   output logic [STAGES-1:0]      o_flush_cmd,
   output logic                   o_redirect_valid,
   output logic [PC_W-1:0]        o_redirect_pc,
   output logic                   o_wd_timeout,
   output logic [CNT_W-1:0]       o_stall_cnt,
   output logic [CNT_W-1:0]       o_flush_cnt
);

   localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;

   hz_state_e         r_state;
   hz_state_e         w_state_nxt;
   logic              r_frz_pend;
   logic [IW-1:0]     r_pend_idx;
   logic [PC_W-1:0]   r_pend_pc;
   logic [WD_W-1:0]   r_wd_cnt;
   logic [WD_W-1:0]   w_wd_nxt;
   logic              r_wd_to;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   logic              w_stall_valid;
   logic [IW-1:0]     w_stall_idx;
   logic [STAGES-1:0] w_stall_mask;
   logic              w_freq_valid;
   logic [IW-1:0]     w_freq_idx;
   logic [STAGES-1:0] w_freq_mask;

   logic              w_pend_valid;
   logic [STAGES-1:0] w_pend_thermo;
   logic              w_new_wins;
   logic              w_cand_valid;
   logic [IW-1:0]     w_cand_idx;
   logic [PC_W-1:0]   w_cand_pc;
   logic [STAGES-1:0] w_cand_low;
   logic              w_apply;
   logic              w_pend_nxt;
   logic              w_stalled;

   prio_thermo #(.W(STAGES), .IW(IW)) u_stall_prio (
      .i_vec   (i_stall_req),
      .o_idx   (w_stall_idx),
      .o_valid (w_stall_valid),
      .o_mask  (w_stall_mask)
   );

   prio_thermo #(.W(STAGES), .IW(IW)) u_flush_prio (
      .i_vec   (i_flush_req),
      .o_idx   (w_freq_idx),
      .o_valid (w_freq_valid),
      .o_mask  (w_freq_mask)
   );

   assign w_pend_valid  = (r_state == ST_PEND) | ((r_state == ST_FROZEN) & r_frz_pend);
   assign w_pend_thermo = STAGES'(thermo_mask(MAX_IDX_W'(r_pend_idx)));

   // The new request wins when it has a mask bit above the pending index.
   // That happens only when its index is strictly older than the pending one.
   assign w_new_wins   = w_freq_valid & (~w_pend_valid | (|(w_freq_mask & ~w_pend_thermo)));
   assign w_cand_valid = w_freq_valid | w_pend_valid;
   assign w_cand_idx   = w_new_wins ? w_freq_idx : r_pend_idx;
   assign w_cand_pc    = w_new_wins ? i_flush_pc[int'(w_freq_idx)*PC_W +: PC_W] : r_pend_pc;
   assign w_cand_low   = STAGES'(thermo_mask(MAX_IDX_W'(w_cand_idx)) >> 1);

   assign w_apply    = ~i_rst & i_rdy & w_cand_valid
                     & ~(w_stall_valid & (w_stall_idx > w_cand_idx));
   assign w_pend_nxt = w_cand_valid & ~w_apply;

   always_comb begin
      o_stall_cmd      = '0;
      o_flush_cmd      = '0;
      o_redirect_valid = 1'b0;
      o_redirect_pc    = '0;
      if (i_rst) begin
         o_stall_cmd = '0;
      end else if (!i_rdy) begin
         o_stall_cmd = '1;
      end else begin
         o_stall_cmd = w_stall_mask;
         if (w_apply) begin
            // The younger stages are killed, so their stalls no longer matter.
            o_stall_cmd      = w_stall_mask & ~w_cand_low;
            o_flush_cmd      = w_cand_low;
            o_redirect_valid = 1'b1;
            o_redirect_pc    = w_cand_pc;
         end
      end
   end

   assign w_stalled = i_rdy & (|o_stall_cmd);

   always_comb begin
      w_wd_nxt = r_wd_cnt;
      if (i_rdy) begin
         if (!w_stalled)                     w_wd_nxt = '0;
         else if (r_wd_cnt < WD_W'(WD_LIMIT)) w_wd_nxt = r_wd_cnt + WD_W'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (!i_rdy)          w_state_nxt = ST_FROZEN;
            else if (w_pend_nxt) w_state_nxt = ST_PEND;
         end
         ST_PEND: begin
            if (!i_rdy)       w_state_nxt = ST_FROZEN;
            else if (w_apply) w_state_nxt = ST_RUN;
         end
         ST_FROZEN: begin
            if (i_rdy) w_state_nxt = w_pend_nxt ? ST_PEND : ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_RUN;
         r_frz_pend <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_frz_pend <= w_pend_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pend_idx  <= '0;
         r_pend_pc   <= '0;
         r_wd_cnt    <= '0;
         r_wd_to     <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_pend_nxt) begin
            r_pend_idx <= w_cand_idx;
            r_pend_pc  <= w_cand_pc;
         end
         if (w_apply)   r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         if (w_stalled) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         r_wd_cnt <= w_wd_nxt;
         if (w_wd_nxt == WD_W'(WD_LIMIT)) r_wd_to <= 1'b1;
      end
   end

   assign o_wd_timeout = r_wd_to;
   assign o_stall_cnt  = r_stall_cnt;
   assign o_flush_cnt  = r_flush_cnt;

endmodule
